osd_spi_master: RTL and testbench



---
 rtl/osd_spi_master.sv | 257 +++++++++++++++++++++++++
 tb/tb_osd_spi_master.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_spi_master.sv
// osd_spi_master
// SPI initiator for the OSD serial port (SPI_SCK / SPI_SS3 / SPI_DI).
// One command is accepted at a time. It becomes a command byte, and a
// write-line command is followed by LINE_BYTES bytes fetched from a
// synchronous buffer. Bytes go out MSB-first. The receiver samples on
// the rising edge of SCK. Every output comes straight from a register.
module osd_spi_master #(
   parameter int CLK_DIV    = 2,
   parameter int LINE_BYTES = 256,
   parameter int SS_GAP     = 4
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_type,
   input  logic [2:0] cmd_line,
   output logic [7:0] rd_addr,
   output logic       rd_en,
   input  logic [7:0] rd_data,
   output logic       busy,
   output logic       done,
   output logic       SPI_SCK,
   output logic       SPI_SS3,
   output logic       SPI_DI
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_TAIL  = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   localparam int          GW         = (SS_GAP > 2) ? $clog2(SS_GAP) : 1;
   localparam logic [7:0]  PH_LAST    = 8'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(SS_GAP - 1);
   localparam logic [8:0]  WL_BYTES   = 9'(LINE_BYTES + 1);
   localparam logic [8:0]  DATA_BYTES = 9'(LINE_BYTES);

   state_t          state_q, state_d;
   logic [7:0]      sh_q, sh_d;          // byte being shifted, MSB next
   logic [7:0]      nxt_q, nxt_d;        // prefetched next data byte
   logic [2:0]      bit_q, bit_d;
   logic [8:0]      byte_q, byte_d;
   logic [8:0]      nbytes_q, nbytes_d;
   logic            wl_q, wl_d;          // current command is a write line
   logic [7:0]      ph_q, ph_d;          // cycles spent in the current SCK phase
   logic            hi_q, hi_d;          // 1 while in the SCK high phase
   logic [GW-1:0]   gap_q, gap_d;
   logic            cap_q, cap_d;        // rd_data holds the requested byte this cycle
   logic            sck_q, sck_d;
   logic            ss_q, ss_d;
   logic            di_q, di_d;
   logic            rdy_q, rdy_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            rden_q, rden_d;
   logic [7:0]      raddr_q, raddr_d;

   logic [7:0]      cmd_byte_s;
   logic [8:0]      byte_inc_s;

   // Map the command type onto the byte that is sent first
   always_comb begin
      cmd_byte_s = 8'h00;
      case (cmd_type)
         2'b00:   cmd_byte_s = 8'h40;
         2'b01:   cmd_byte_s = 8'h41;
         2'b10:   cmd_byte_s = {5'b00100, cmd_line};
         default: cmd_byte_s = 8'h00;
      endcase
   end

   assign byte_inc_s = byte_q + 9'd1;

   // State register and registered outputs; reset forces the SPI port idle at once
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         sh_q     <= 8'h00;
         nxt_q    <= 8'h00;
         bit_q    <= 3'd7;
         byte_q   <= 9'd0;
         nbytes_q <= 9'd0;
         wl_q     <= 1'b0;
         ph_q     <= 8'd0;
         hi_q     <= 1'b0;
         gap_q    <= '0;
         cap_q    <= 1'b0;
         sck_q    <= 1'b0;
         ss_q     <= 1'b1;
         di_q     <= 1'b0;
         rdy_q    <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rden_q   <= 1'b0;
         raddr_q  <= 8'd0;
      end else begin
         state_q  <= state_d;
         sh_q     <= sh_d;
         nxt_q    <= nxt_d;
         bit_q    <= bit_d;
         byte_q   <= byte_d;
         nbytes_q <= nbytes_d;
         wl_q     <= wl_d;
         ph_q     <= ph_d;
         hi_q     <= hi_d;
         gap_q    <= gap_d;
         cap_q    <= cap_d;
         sck_q    <= sck_d;
         ss_q     <= ss_d;
         di_q     <= di_d;
         rdy_q    <= rdy_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         rden_q   <= rden_d;
         raddr_q  <= raddr_d;
      end
   end

   // Next-state logic: command accept, bit/byte sequencing, prefetch, tail and gap
   always_comb begin
      state_d  = state_q;
      sh_d     = sh_q;
      bit_d    = bit_q;
      byte_d   = byte_q;
      nbytes_d = nbytes_q;
      wl_d     = wl_q;
      ph_d     = ph_q;
      hi_d     = hi_q;
      gap_d    = gap_q;
      sck_d    = sck_q;
      ss_d     = ss_q;
      di_d     = di_q;
      rdy_d    = rdy_q;
      busy_d   = busy_q;
      raddr_d  = raddr_q;
      done_d   = 1'b0;
      rden_d   = 1'b0;
      cap_d    = rden_q;
      if (cap_q) begin
         nxt_d = rd_data;
      end else begin
         nxt_d = nxt_q;
      end

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               rdy_d  = 1'b0;
               busy_d = 1'b1;
               ph_d   = 8'd0;
               hi_d   = 1'b0;
               bit_d  = 3'd7;
               byte_d = 9'd0;
               gap_d  = '0;
               wl_d   = (cmd_type == 2'b10);
               if (cmd_type == 2'b11) begin
                  // reserved: no transfer, SS3 stays high, just run the gap
                  state_d = S_GAP;
               end else begin
                  state_d  = S_SHIFT;
                  ss_d     = 1'b0;
                  sck_d    = 1'b0;
                  sh_d     = cmd_byte_s;
                  di_d     = cmd_byte_s[7];
                  nbytes_d = (cmd_type == 2'b10) ? WL_BYTES : 9'd1;
                  if (cmd_type == 2'b10) begin
                     // byte 1 is data byte 0: fetch it during the command byte
                     rden_d  = 1'b1;
                     raddr_d = 8'd0;
                  end else begin
                     rden_d  = 1'b0;
                  end
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_SHIFT: begin
            if (ph_q == PH_LAST) begin
               ph_d = 8'd0;
               if (!hi_q) begin
                  hi_d  = 1'b1;
                  sck_d = 1'b1;
               end else begin
                  hi_d  = 1'b0;
                  sck_d = 1'b0;
                  if (bit_q == 3'd0) begin
                     byte_d = byte_inc_s;
                     bit_d  = 3'd7;
                     if (byte_inc_s == nbytes_q) begin
                        state_d = S_TAIL;
                     end else begin
                        sh_d = nxt_q;
                        di_d = nxt_q[7];
                        if (wl_q && (byte_inc_s < DATA_BYTES)) begin
                           rden_d  = 1'b1;
                           raddr_d = byte_inc_s[7:0];
                        end else begin
                           rden_d  = 1'b0;
                        end
                     end
                  end else begin
                     bit_d = bit_q - 3'd1;
                     sh_d  = {sh_q[6:0], 1'b0};
                     di_d  = sh_q[6];
                  end
               end
            end else begin
               ph_d = ph_q + 8'd1;
            end
         end

         S_TAIL: begin
            if (ph_q == PH_LAST) begin
               state_d = S_GAP;
               ss_d    = 1'b1;
               gap_d   = '0;
            end else begin
               ph_d = ph_q + 8'd1;
            end
         end

         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               rdy_d   = 1'b1;
               busy_d  = 1'b0;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            ss_d    = 1'b1;
            sck_d   = 1'b0;
            rdy_d   = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign cmd_ready = rdy_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign rd_en     = rden_q;
   assign rd_addr   = raddr_q;
   assign SPI_SCK   = sck_q;
   assign SPI_SS3   = ss_q;
   assign SPI_DI    = di_q;

endmodule

// File: tb/tb_osd_spi_master.sv
// Bench for osd_spi_master. There are two instances: CLK_DIV=2 and
// CLK_DIV=3, both with LINE_BYTES=4 and SS_GAP=4. A timing model derives
// every output on every cycle from the cycle offset since accept. A
// receiver decodes the SPI bytes, and hand-computed literals pin the model.
module tb_osd_spi_master;
   localparam int LB  = 4;
   localparam int GAP = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] valid;
   logic [1:0] ctype;
   logic [2:0] cline;
   wire  [1:0] ready, busy_w, done_w, sck_w, ss_w, di_w, rden_w;
   wire  [7:0] addr_w [2];
   logic [7:0] rdata [2];
   logic [7:0] mem [0:3];

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;

   // model state, per instance
   logic       m_act [2];
   logic       m_res [2];
   logic       m_wl  [2];
   int         m_t0  [2];
   int         m_n   [2];
   logic [7:0] m_bytes [2][0:7];

   // receiver and measurements, per instance
   logic [7:0] rx_sh  [2];
   int         rx_cnt [2];
   int         rx_n   [2];
   logic [7:0] rx_buf [2][0:63];
   int         tot_edges [2];
   int         rden_cnt  [2];
   int         n_falls   [2];
   int         low_cnt [2];
   int         last_low [2];
   int         hi_cnt [2];
   int         min_hi [2];
   logic       rose [2];
   int         last_lat [2];
   logic       prev_ss [2];
   logic       prev_sck [2];
   logic       prev_di [2];

   // snapshots taken before each directed command
   int b_rx, b_edge, b_rd, b_fall;

   osd_spi_master #(.CLK_DIV(2), .LINE_BYTES(LB), .SS_GAP(GAP)) u_dut0 (
      .clk_sys(clk), .reset_n(reset_n), .cmd_valid(valid[0]), .cmd_ready(ready[0]),
      .cmd_type(ctype), .cmd_line(cline), .rd_addr(addr_w[0]), .rd_en(rden_w[0]),
      .rd_data(rdata[0]), .busy(busy_w[0]), .done(done_w[0]), .SPI_SCK(sck_w[0]),
      .SPI_SS3(ss_w[0]), .SPI_DI(di_w[0]));

   osd_spi_master #(.CLK_DIV(3), .LINE_BYTES(LB), .SS_GAP(GAP)) u_dut1 (
      .clk_sys(clk), .reset_n(reset_n), .cmd_valid(valid[1]), .cmd_ready(ready[1]),
      .cmd_type(ctype), .cmd_line(cline), .rd_addr(addr_w[1]), .rd_en(rden_w[1]),
      .rd_data(rdata[1]), .busy(busy_w[1]), .done(done_w[1]), .SPI_SCK(sck_w[1]),
      .SPI_SS3(ss_w[1]), .SPI_DI(di_w[1]));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // synchronous line buffer: data appears the cycle after rd_en
   always @(posedge clk) begin
      if (rden_w[0]) rdata[0] <= mem[addr_w[0][1:0]];
      if (rden_w[1]) rdata[1] <= mem[addr_w[1][1:0]];
   end

   function automatic int cdv(input int i);
      return (i == 0) ? 2 : 3;
   endfunction

   task automatic chk(input string nm, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // per-cycle compare against the timing model, plus receiver and measurements
   always @(negedge clk) begin
      int c, cd, sh, ln, idx;
      int e_ss, e_sck, e_busy, e_done, e_rd, e_addr, e_di;
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) begin
            chk($sformatf("rst_ss3[%0d]", i),   int'(ss_w[i]), 1);
            chk($sformatf("rst_sck[%0d]", i),   int'(sck_w[i]), 0);
            chk($sformatf("rst_di[%0d]", i),    int'(di_w[i]), 0);
            chk($sformatf("rst_ready[%0d]", i), int'(ready[i]), 1);
            chk($sformatf("rst_busy[%0d]", i),  int'(busy_w[i]), 0);
            chk($sformatf("rst_done[%0d]", i),  int'(done_w[i]), 0);
            chk($sformatf("rst_rden[%0d]", i),  int'(rden_w[i]), 0);
            chk($sformatf("rst_addr[%0d]", i),  int'(addr_w[i]), 0);
            m_act[i] = 1'b0;
            rx_cnt[i] = 0;
            prev_ss[i] = 1'b1;
            prev_sck[i] = 1'b0;
            prev_di[i] = 1'b0;
            hi_cnt[i] = 0;
            low_cnt[i] = 0;
            rose[i] = 1'b0;
         end else begin
            if (m_act[i]) begin
               c  = cyc - m_t0[i];
               cd = cdv(i);
               sh = m_res[i] ? 0 : 16 * cd * m_n[i];
               ln = m_res[i] ? 0 : sh + cd;
               e_ss   = (c >= 1 && c <= ln) ? 0 : 1;
               e_sck  = (c >= 1 && c <= sh && ((c - 1) % (2 * cd)) >= cd) ? 1 : 0;
               e_busy = (c <= ln + GAP) ? 1 : 0;
               e_done = (c == ln + GAP + 1) ? 1 : 0;
               e_rd   = 0;
               e_addr = 0;
               if (m_wl[i] && c >= 1 && c <= sh && ((c - 1) % (16 * cd)) == 0
                   && ((c - 1) / (16 * cd)) < LB) begin
                  e_rd   = 1;
                  e_addr = (c - 1) / (16 * cd);
               end
               chk($sformatf("ss3[%0d] c=%0d", i, c),   int'(ss_w[i]), e_ss);
               chk($sformatf("sck[%0d] c=%0d", i, c),   int'(sck_w[i]), e_sck);
               chk($sformatf("busy[%0d] c=%0d", i, c),  int'(busy_w[i]), e_busy);
               chk($sformatf("ready[%0d] c=%0d", i, c), int'(ready[i]), 1 - e_busy);
               chk($sformatf("done[%0d] c=%0d", i, c),  int'(done_w[i]), e_done);
               chk($sformatf("rden[%0d] c=%0d", i, c),  int'(rden_w[i]), e_rd);
               if (e_rd == 1)
                  chk($sformatf("rdaddr[%0d] c=%0d", i, c), int'(addr_w[i]), e_addr);
               if (c >= 1 && c <= sh) begin
                  idx  = (c - 1) / (2 * cd);
                  e_di = int'(m_bytes[i][idx / 8][7 - (idx % 8)]);
                  chk($sformatf("di[%0d] c=%0d", i, c), int'(di_w[i]), e_di);
               end
               if (e_done == 1) begin
                  m_act[i] = 1'b0;
                  last_lat[i] = c;
               end
            end else begin
               chk($sformatf("idle_ss3[%0d]", i),   int'(ss_w[i]), 1);
               chk($sformatf("idle_sck[%0d]", i),   int'(sck_w[i]), 0);
               chk($sformatf("idle_busy[%0d]", i),  int'(busy_w[i]), 0);
               chk($sformatf("idle_ready[%0d]", i), int'(ready[i]), 1);
               chk($sformatf("idle_done[%0d]", i),  int'(done_w[i]), 0);
               chk($sformatf("idle_rden[%0d]", i),  int'(rden_w[i]), 0);
            end

            // receiver: sample DI when SCK is first seen high
            if (sck_w[i] && !prev_sck[i]) begin
               tot_edges[i]++;
               if (!ss_w[i]) begin
                  rx_sh[i] = {rx_sh[i][6:0], di_w[i]};
                  rx_cnt[i]++;
                  if (rx_cnt[i] == 8) begin
                     rx_buf[i][rx_n[i] % 64] = rx_sh[i];
                     rx_n[i]++;
                     rx_cnt[i] = 0;
                  end
               end
            end
            if (sck_w[i] && prev_sck[i] && !ss_w[i])
               chk($sformatf("di_stable_hi[%0d]", i), int'(di_w[i]), int'(prev_di[i]));
            if (rden_w[i]) rden_cnt[i]++;
            if (ss_w[i] && !prev_ss[i]) begin
               last_low[i] = low_cnt[i];
               low_cnt[i] = 0;
               hi_cnt[i] = 0;
               rose[i] = 1'b1;
               rx_cnt[i] = 0;
            end
            if (!ss_w[i] && prev_ss[i]) begin
               n_falls[i]++;
               if (rose[i] && hi_cnt[i] < min_hi[i]) min_hi[i] = hi_cnt[i];
               low_cnt[i] = 0;
            end
            if (ss_w[i]) hi_cnt[i]++;
            else         low_cnt[i]++;

            // accept: snapshot the command into the model
            if (!m_act[i] && valid[i] && ready[i]) begin
               m_act[i] = 1'b1;
               m_t0[i]  = cyc;
               m_res[i] = (ctype == 2'b11);
               m_wl[i]  = (ctype == 2'b10);
               case (ctype)
                  2'b00:   begin m_n[i] = 1; m_bytes[i][0] = 8'h40; end
                  2'b01:   begin m_n[i] = 1; m_bytes[i][0] = 8'h41; end
                  2'b10: begin
                     m_n[i] = 1 + LB;
                     m_bytes[i][0] = 8'h20 + 8'(cline);
                     for (int k = 0; k < LB; k++) m_bytes[i][k + 1] = mem[k];
                  end
                  default: m_n[i] = 0;
               endcase
            end
            prev_ss[i]  = ss_w[i];
            prev_sck[i] = sck_w[i];
            prev_di[i]  = di_w[i];
         end
      end
   end

   // issue one command, optionally keep cmd_valid high a few cycles, wait for done
   task automatic run_cmd(input int i, input logic [1:0] t, input logic [2:0] l, input int hold);
      logic got;
      b_rx = rx_n[i]; b_edge = tot_edges[i]; b_rd = rden_cnt[i]; b_fall = n_falls[i];
      @(posedge clk); #1;
      ctype = t; cline = l; valid[i] = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (ready[i]) got = 1'b1;
      end
      if (!got) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      repeat (hold) begin @(posedge clk); #1; end
      valid[i] = 1'b0;
      ctype = 2'($urandom);
      cline = 3'($urandom);
      got = 1'b0;
      for (int k = 0; k < 3000 && !got; k++) begin
         @(negedge clk);
         if (done_w[i]) got = 1'b1;
      end
      if (!got) chk("done_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_wl [5];
      logic got;
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 1'b0; rx_n[i] = 0; rx_cnt[i] = 0; tot_edges[i] = 0;
         rden_cnt[i] = 0; n_falls[i] = 0; min_hi[i] = 1000000; last_lat[i] = 0;
         last_low[i] = 0; rx_sh[i] = 8'h00;
      end
      reset_n = 1'b0; valid = 2'b00; ctype = 2'b00; cline = 3'd0;
      for (int k = 0; k < 4; k++) mem[k] = 8'h00;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // enable on CLK_DIV=2: 0x41, SS3 low 34 cycles, done 39 after accept
      run_cmd(0, 2'b01, 3'd0, 0);
      chk("en_bytes", rx_n[0] - b_rx, 1);
      chk("en_value", int'(rx_buf[0][b_rx % 64]), 8'h41);
      chk("en_edges", tot_edges[0] - b_edge, 8);
      chk("en_ss_low", last_low[0], 34);
      chk("en_latency", last_lat[0], 39);

      // write line 5, buffer AA 55 0F F0
      mem[0] = 8'hAA; mem[1] = 8'h55; mem[2] = 8'h0F; mem[3] = 8'hF0;
      exp_wl = '{8'h25, 8'hAA, 8'h55, 8'h0F, 8'hF0};
      run_cmd(0, 2'b10, 3'd5, 2);
      chk("wl_bytes", rx_n[0] - b_rx, 5);
      for (int k = 0; k < 5; k++)
         chk($sformatf("wl_byte%0d", k), int'(rx_buf[0][(b_rx + k) % 64]), int'(exp_wl[k]));
      chk("wl_rden_count", rden_cnt[0] - b_rd, 4);
      chk("wl_ss_low", last_low[0], 162);
      chk("wl_latency", last_lat[0], 167);

      // disable on CLK_DIV=3
      run_cmd(1, 2'b00, 3'd0, 1);
      chk("dis_value", int'(rx_buf[1][b_rx % 64]), 8'h40);
      chk("dis_edges", tot_edges[1] - b_edge, 8);
      chk("dis_ss_low", last_low[1], 51);
      chk("dis_latency", last_lat[1], 56);

      // reserved type: no SCK, no SS3 activity, done SS_GAP+1 after accept
      run_cmd(0, 2'b11, 3'd0, 3);
      chk("res_edges", tot_edges[0] - b_edge, 0);
      chk("res_falls", n_falls[0] - b_fall, 0);
      chk("res_latency", last_lat[0], 5);

      // cmd_valid held high: back-to-back commands
      b_fall = n_falls[0];
      @(posedge clk); #1;
      ctype = 2'($urandom_range(0, 2)); cline = 3'($urandom); valid[0] = 1'b1;
      for (int n = 0; n < 4; n++) begin
         got = 1'b0;
         for (int k = 0; k < 1000 && !got; k++) begin
            @(negedge clk);
            if (ready[0]) got = 1'b1;
         end
         if (!got) chk("b2b_accept_timeout", 0, 1);
         @(posedge clk); #1;
         ctype = 2'($urandom_range(0, 2)); cline = 3'($urandom);
      end
      valid[0] = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 1000 && !got; k++) begin
         @(negedge clk);
         if (done_w[0]) got = 1'b1;
      end
      if (!got) chk("b2b_done_timeout", 0, 1);
      @(posedge clk); #1;
      chk("b2b_falls", n_falls[0] - b_fall, 4);
      chk("b2b_gap_ge_ssgap", int'(min_hi[0] >= GAP), 1);
      chk("b2b_gap", min_hi[0], GAP + 1);

      // randomized commands on both instances
      for (int n = 0; n < 24; n++) begin
         int d;
         logic [1:0] t;
         d = $urandom_range(0, 1);
         t = 2'($urandom_range(0, 3));
         for (int k = 0; k < 4; k++) mem[k] = 8'($urandom);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         run_cmd(d, t, 3'($urandom), $urandom_range(0, 3));
         chk($sformatf("rnd%0d_bytes", n), rx_n[d] - b_rx,
             (t == 2'b11) ? 0 : ((t == 2'b10) ? 5 : 1));
      end

      // reset in the middle of a write line's second byte, SCK high
      @(posedge clk); #1;
      ctype = 2'b10; cline = 3'd2; valid[0] = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (ready[0]) got = 1'b1;
      end
      if (!got) chk("mid_accept_timeout", 0, 1);
      @(posedge clk); #1;
      valid[0] = 1'b0;
      repeat (42) @(posedge clk);
      #1;
      chk("mid_pre_sck", int'(sck_w[0]), 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_ss3", int'(ss_w[0]), 1);
      chk("mid_rst_sck", int'(sck_w[0]), 0);
      chk("mid_rst_ready", int'(ready[0]), 1);
      chk("mid_rst_busy", int'(busy_w[0]), 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      b_rd = rden_cnt[0];
      repeat (100) @(posedge clk);
      #1;
      chk("mid_no_rden", rden_cnt[0] - b_rd, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
